// File: rtl/ysyx_22041752_commit_trace_pkg.sv
// Shared types and widths for the retired-instruction trace buffer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Contents: FSM state encoding, commit-record struct, datapath width constants.
package ysyx_22041752_commit_trace_pkg;

   localparam int PC_WD      = 64;
   localparam int INST_WD    = 32;
   localparam int RF_DATA_WD = 64;
   localparam int RF_ADDR_WD = 5;

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2
   } trace_state_t;

   typedef struct packed {
      logic [PC_WD-1:0]      pc;
      logic [INST_WD-1:0]    inst;
      logic                  wen;
      logic [RF_ADDR_WD-1:0] wnum;
      logic [RF_DATA_WD-1:0] wdata;
   } commit_rec_t;

endpackage

// File: rtl/ysyx_22041752_commit_trace_if.sv
// Bundle of the commit-stream input, control triggers and drain port of the trace buffer.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready on the drain side; the commit side has none.
// Modports: master = commit producer / trace consumer side, slave = trace buffer.
interface ysyx_22041752_commit_trace_if
   import ysyx_22041752_commit_trace_pkg::*;
#(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   // commit stream
   logic                  ws_valid;
   logic [PC_WD-1:0]      wb_pc;
   logic [INST_WD-1:0]    wb_inst;
   logic                  wb_rf_wen;
   logic [RF_ADDR_WD-1:0] wb_rf_wnum;
   logic [RF_DATA_WD-1:0] wb_rf_wdata;
   // control
   logic                  stop;
   logic                  abort;
   logic                  clear;
   // drain port
   logic                  out_valid;
   logic                  out_ready;
   logic [PC_WD-1:0]      out_pc;
   logic [INST_WD-1:0]    out_inst;
   logic                  out_wen;
   logic [RF_ADDR_WD-1:0] out_wnum;
   logic [RF_DATA_WD-1:0] out_wdata;
   logic                  out_last;
   // status
   logic [CW-1:0]         count;
   logic                  frozen;
   logic                  done;

   modport master (
      output ws_valid, wb_pc, wb_inst, wb_rf_wen, wb_rf_wnum, wb_rf_wdata,
      output stop, abort, clear, out_ready,
      input  out_valid, out_pc, out_inst, out_wen, out_wnum, out_wdata, out_last,
      input  count, frozen, done
   );

   modport slave (
      input  ws_valid, wb_pc, wb_inst, wb_rf_wen, wb_rf_wnum, wb_rf_wdata,
      input  stop, abort, clear, out_ready,
      output out_valid, out_pc, out_inst, out_wen, out_wnum, out_wdata, out_last,
      output count, frozen, done
   );

endinterface

// File: rtl/ysyx_22041752_trace_ram.sv
// DEPTH x commit-record storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller owns all flow control.
// Ports: clk, resetn (async clear of every entry), we_i/waddr_i/wdata_i, raddr_i/rdata_o.
module ysyx_22041752_trace_ram
   import ysyx_22041752_commit_trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          resetn,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  commit_rec_t   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output commit_rec_t   rdata_o
);

   commit_rec_t mem_q [DEPTH];

   // Entries are cleared on reset so the drain port reads zero out of reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_22041752_commit_trace.sv
// Retired-instruction trace ring: keeps the last DEPTH commits, freezes on stop/abort, drains oldest-first.
// Latency: capture 1 cycle; trigger to first out_valid 1 cycle; drain 1 record/cycle.
// Backpressure: drain record held stable while out_valid & !out_ready; commit input is never stalled.
// Ports: clk, resetn (async, active-low), tr (commit stream, triggers, drain port, status).
module ysyx_22041752_commit_trace
   import ysyx_22041752_commit_trace_pkg::*;
#(
   parameter int DEPTH = 16
)(
   input  logic                         clk,
   input  logic                         resetn,
   ysyx_22041752_commit_trace_if.slave  tr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   trace_state_t  state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          ram_we;
   commit_rec_t   wr_rec;
   commit_rec_t   rd_rec;
   logic          out_valid;
   logic          pop;

   always_comb begin
      wr_rec       = '0;
      wr_rec.pc    = tr.wb_pc;
      wr_rec.inst  = tr.wb_inst;
      wr_rec.wen   = tr.wb_rf_wen;
      wr_rec.wnum  = tr.wb_rf_wnum;
      wr_rec.wdata = tr.wb_rf_wdata;
   end

   ysyx_22041752_trace_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .resetn  (resetn),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_rec),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_rec)
   );

   assign out_valid = (state_q == ST_DRAIN) && (count_q != '0);
   assign pop       = out_valid && tr.out_ready;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ram_we   = 1'b0;

      unique case (state_q)
         ST_CAPTURE: begin
            if (tr.clear) begin
               // clear wins over a same-cycle commit and trigger
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               count_d  = '0;
            end else begin
               if (tr.ws_valid) begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = (count_q == FULL) ? count_q : count_q + CW'(1);
               end
               if (tr.stop || tr.abort) begin
                  // Oldest entry sits count_d slots behind the next write slot.
                  // When full, the low bits of count_d are zero, so this lands on wr_ptr_d.
                  rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                  state_d  = (count_d != '0) ? ST_DRAIN : ST_DONE;
               end
            end
         end

         ST_DRAIN: begin
            if (pop) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
               count_d  = count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            if (tr.clear) begin
               state_d  = ST_CAPTURE;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               count_d  = '0;
            end
         end

         default: begin
            state_d = ST_CAPTURE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_CAPTURE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign tr.out_valid = out_valid;
   assign tr.out_last  = out_valid && (count_q == CW'(1));
   assign tr.out_pc    = rd_rec.pc;
   assign tr.out_inst  = rd_rec.inst;
   assign tr.out_wen   = rd_rec.wen;
   assign tr.out_wnum  = rd_rec.wnum;
   assign tr.out_wdata = rd_rec.wdata;
   assign tr.count     = count_q;
   assign tr.frozen    = (state_q != ST_CAPTURE);
   assign tr.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ysyx_22041752_commit_trace.sv
// Directed self-checking bench for the commit trace ring with DEPTH=4.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised by toggling out_ready during a drain.
module tb_ysyx_22041752_commit_trace;

   localparam int DEPTH = 4;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   ysyx_22041752_commit_trace_if #(.DEPTH(DEPTH)) tr ();

   ysyx_22041752_commit_trace #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .tr     (tr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Record fields are all derived from the pc so the bench can predict them.
   function automatic logic [31:0] inst_of(input logic [63:0] pc);
      return pc[31:0] ^ 32'h0000_0013;
   endfunction

   function automatic logic [63:0] wdata_of(input logic [63:0] pc);
      return {32'hdead_0000, pc[31:0]};
   endfunction

   task automatic drive_rec(input logic [63:0] pc);
      tr.ws_valid    = 1'b1;
      tr.wb_pc       = pc;
      tr.wb_inst     = inst_of(pc);
      tr.wb_rf_wen   = pc[2];
      tr.wb_rf_wnum  = pc[6:2];
      tr.wb_rf_wdata = wdata_of(pc);
   endtask

   task automatic retire(input logic [63:0] pc);
      drive_rec(pc);
      tick();
      tr.ws_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      tr.clear = 1'b1;
      tick();
      tr.clear = 1'b0;
   endtask

   task automatic check_rec(input string tag, input logic [63:0] pc, input logic last);
      check({tag, "_valid"}, 64'(tr.out_valid), 64'd1);
      check({tag, "_pc"},    tr.out_pc, pc);
      check({tag, "_last"},  64'(tr.out_last), 64'(last));
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      resetn       = 1'b1;
      tr.ws_valid  = 1'b0;
      tr.wb_pc     = '0;
      tr.wb_inst   = '0;
      tr.wb_rf_wen = 1'b0;
      tr.wb_rf_wnum  = '0;
      tr.wb_rf_wdata = '0;
      tr.stop      = 1'b0;
      tr.abort     = 1'b0;
      tr.clear     = 1'b0;
      tr.out_ready = 1'b0;

      // reset state
      #1 resetn = 1'b0;
      #1;
      check("rst_valid",  64'(tr.out_valid), 64'd0);
      check("rst_last",   64'(tr.out_last),  64'd0);
      check("rst_count",  64'(tr.count),     64'd0);
      check("rst_frozen", 64'(tr.frozen),    64'd0);
      check("rst_done",   64'(tr.done),      64'd0);
      check("rst_pc",     tr.out_pc,         64'd0);
      check("rst_wdata",  tr.out_wdata,      64'd0);
      tick();
      tick();
      resetn = 1'b1;
      tick();

      // partial fill: 3 records, drain with out_ready high
      retire(64'h8000_0000);
      check("pf_count1", 64'(tr.count), 64'd1);
      retire(64'h8000_0004);
      retire(64'h8000_0008);
      check("pf_count3",  64'(tr.count),  64'd3);
      check("pf_frozen0", 64'(tr.frozen), 64'd0);
      check("pf_valid0",  64'(tr.out_valid), 64'd0);
      tr.stop      = 1'b1;
      tr.out_ready = 1'b1;
      tick();
      tr.stop = 1'b0;
      check("pf_frozen1", 64'(tr.frozen), 64'd1);
      check_rec("pf_r0", 64'h8000_0000, 1'b0);
      check("pf_r0_inst",  64'(tr.out_inst), 64'(inst_of(64'h8000_0000)));
      check("pf_r0_wnum",  64'(tr.out_wnum), 64'd0);
      tick();
      check_rec("pf_r1", 64'h8000_0004, 1'b0);
      check("pf_r1_wen",   64'(tr.out_wen), 64'd1);
      check("pf_r1_wnum",  64'(tr.out_wnum), 64'd1);
      tick();
      check_rec("pf_r2", 64'h8000_0008, 1'b1);
      check("pf_r2_wdata", tr.out_wdata, wdata_of(64'h8000_0008));
      tick();
      check("pf_done",   64'(tr.done),      64'd1);
      check("pf_valid",  64'(tr.out_valid), 64'd0);
      check("pf_count0", 64'(tr.count),     64'd0);
      pulse_clear();
      check("pf_clr_frozen", 64'(tr.frozen), 64'd0);
      check("pf_clr_done",   64'(tr.done),   64'd0);

      // wrap-around: 6 records into 4 slots, abort, drain the last 4
      tr.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         retire(64'h8000_0000 + 64'(4 * k));
      end
      check("wr_count4", 64'(tr.count), 64'd4);
      tr.abort = 1'b1;
      tick();
      tr.abort     = 1'b0;
      tr.out_ready = 1'b1;
      check("wr_count_drain", 64'(tr.count), 64'd4);
      for (int k = 2; k < 6; k++) begin
         check_rec($sformatf("wr_k%0d", k), 64'h8000_0000 + 64'(4 * k), (k == 5));
         tick();
      end
      check("wr_done",  64'(tr.done),      64'd1);
      check("wr_valid", 64'(tr.out_valid), 64'd0);
      pulse_clear();

      // simultaneous commit and stop: that record drains last
      retire(64'h8000_0004);
      retire(64'h8000_0008);
      drive_rec(64'h8000_000c);
      tr.stop = 1'b1;
      tick();
      tr.stop     = 1'b0;
      tr.ws_valid = 1'b0;
      check("sim_count3", 64'(tr.count), 64'd3);
      check_rec("sim_r0", 64'h8000_0004, 1'b0);
      tick();
      check_rec("sim_r1", 64'h8000_0008, 1'b0);
      tick();
      check_rec("sim_r2", 64'h8000_000c, 1'b1);
      tick();
      check("sim_done", 64'(tr.done), 64'd1);
      pulse_clear();

      // empty trigger goes straight to DONE
      tr.stop = 1'b1;
      tick();
      tr.stop = 1'b0;
      check("emp_done",   64'(tr.done),      64'd1);
      check("emp_frozen", 64'(tr.frozen),    64'd1);
      check("emp_valid",  64'(tr.out_valid), 64'd0);
      tick();
      check("emp_valid2", 64'(tr.out_valid), 64'd0);
      pulse_clear();

      // backpressure: each record stalls one cycle before it is taken
      tr.out_ready = 1'b0;
      retire(64'h9000_0000);
      retire(64'h9000_0004);
      retire(64'h9000_0008);
      tr.stop = 1'b1;
      tick();
      tr.stop = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tr.out_ready = 1'b0;
         check_rec($sformatf("bp_a%0d", j), 64'h9000_0000 + 64'(4 * j), (j == 2));
         check($sformatf("bp_cnt%0d", j), 64'(tr.count), 64'(3 - j));
         tick();
         check_rec($sformatf("bp_h%0d", j), 64'h9000_0000 + 64'(4 * j), (j == 2));
         check($sformatf("bp_hd%0d", j), tr.out_wdata, wdata_of(64'h9000_0000 + 64'(4 * j)));
         tr.out_ready = 1'b1;
         tick();
      end
      check("bp_done",  64'(tr.done),  64'd1);
      check("bp_count", 64'(tr.count), 64'd0);

      // clear in DONE, then capture again
      pulse_clear();
      retire(64'ha000_0000);
      retire(64'ha000_0004);
      check("clr_count2", 64'(tr.count),  64'd2);
      check("clr_frozen", 64'(tr.frozen), 64'd0);
      check("clr_done",   64'(tr.done),   64'd0);
      // clear in CAPTURE drops a same-cycle commit
      drive_rec(64'ha000_0008);
      tr.clear = 1'b1;
      tick();
      tr.clear    = 1'b0;
      tr.ws_valid = 1'b0;
      check("clr_cap_count", 64'(tr.count), 64'd0);

      // reset mid-drain abandons the drain
      retire(64'hb000_0000);
      retire(64'hb000_0004);
      tr.stop      = 1'b1;
      tr.out_ready = 1'b1;
      tick();
      tr.stop = 1'b0;
      tick();
      check_rec("rd_mid", 64'hb000_0004, 1'b1);
      resetn = 1'b0;
      #1;
      check("rd_valid",  64'(tr.out_valid), 64'd0);
      check("rd_count",  64'(tr.count),     64'd0);
      check("rd_frozen", 64'(tr.frozen),    64'd0);
      check("rd_pc",     tr.out_pc,         64'd0);
      tick();
      resetn = 1'b1;
      tick();
      tr.stop = 1'b1;
      tick();
      tr.stop = 1'b0;
      check("rd_stop_done",  64'(tr.done),      64'd1);
      check("rd_stop_valid", 64'(tr.out_valid), 64'd0);
      tick();
      check("rd_stop_valid2", 64'(tr.out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
